// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_pkg: shared types, field widths and helpers for the pipeline stage register
package pipe_stage_pkg;

  // Occupancy of the stage: the state code is the number of held entries
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int WB_W       = 2;
  localparam int MEM_W      = 2;
  localparam int EX_W       = 7;
  localparam int CTRL_W_DEF = WB_W + MEM_W + EX_W;
  localparam int CNT_W      = 16;

  function automatic logic [1:0] occ_of(input state_e s);
    return (s == TWO) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter
  import pipe_stage_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clear_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  // count up on inc, hold at the ceiling, clear on reset or request
  always_ff @(posedge clk_i) begin
    if (!rst_n || clear_i) r_cnt <= '0;
    else if (inc_i && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with two-entry skid buffer and N-source flush
// Optional PIPE_STAGE_PERF_EN adds saturating stall and flush counters.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W  = 80,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int FLUSH_N = 2
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [FLUSH_N-1:0] flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  state_e            r_state, w_state;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl, w_main_ctrl, w_skid_ctrl;
  logic [DATA_W-1:0] r_main_data, r_skid_data, w_main_data, w_skid_data;
  logic              w_in_fire, w_out_fire, w_flush;

  // handshake status depends only on registered state, so ready never sees out_ready_i
  assign in_ready_o  = r_state != TWO;
  assign out_valid_o = r_state != EMPTY;
  assign occupancy_o = occ_of(r_state);
  assign out_ctrl_o  = out_valid_o ? r_main_ctrl : '0;
  assign out_data_o  = out_valid_o ? r_main_data : '0;
  assign w_in_fire   = in_valid_i & in_ready_o;
  assign w_out_fire  = out_valid_o & out_ready_i;
  assign w_flush     = |flush_i;

  // next state and entry contents; flush overrides any handshake in the same cycle
  always_comb begin
    w_state     = r_state;
    w_main_ctrl = r_main_ctrl;
    w_main_data = r_main_data;
    w_skid_ctrl = r_skid_ctrl;
    w_skid_data = r_skid_data;
    case (r_state)
      EMPTY: if (w_in_fire) begin
        w_state     = ONE;
        w_main_ctrl = in_ctrl_i;
        w_main_data = in_data_i;
      end
      ONE: if (w_in_fire && w_out_fire) begin
        w_main_ctrl = in_ctrl_i;
        w_main_data = in_data_i;
      end else if (w_in_fire) begin
        w_state     = TWO;
        w_skid_ctrl = in_ctrl_i;
        w_skid_data = in_data_i;
      end else if (w_out_fire) begin
        w_state = EMPTY;
      end
      TWO: if (w_out_fire) begin
        w_state     = ONE;
        w_main_ctrl = r_skid_ctrl;
        w_main_data = r_skid_data;
      end
      default: w_state = EMPTY;
    endcase
    if (w_flush) begin
      w_state     = EMPTY;
      w_main_ctrl = '0;
      w_main_data = '0;
      w_skid_ctrl = '0;
      w_skid_data = '0;
    end
  end

  // state and storage registers; reset squashes exactly like a flush
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state;
      r_main_ctrl <= w_main_ctrl;
      r_main_data <= w_main_data;
      r_skid_ctrl <= w_skid_ctrl;
      r_skid_data <= w_skid_data;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall_inc, w_flush_inc;

  assign w_stall_inc = out_valid_o & ~out_ready_i;
  assign w_flush_inc = w_flush & (r_state != EMPTY);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .inc_i   (w_stall_inc),
    .clear_i (1'b0),
    .cnt_o   (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .inc_i   (w_flush_inc),
    .clear_i (1'b0),
    .cnt_o   (flush_cnt_o)
  );
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed, per-stage hand-written registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a flat data bundle with a valid/ready handshake, a two-entry skid buffer for full throughput under backpressure, and an N-source flush. Flush and reset squash the stage into bubbles, with control zeroed. It sits between any two adjacent pipeline stages of the 16-bit core.

## Interface
- DATA_W, 80: payload bits (PC, operands, immediates, register indices, packed by the user).
- CTRL_W, 11: control bits (WB 2 + MEM 2 + EX 7 by default).
- FLUSH_N, 2: number of independent flush sources (e.g. data hazard, branch).

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush_i  in  FLUSH_N  any bit high squashes stage contents
- in_valid_i  in  1  upstream has a bundle
- in_ready_o  out  1  stage can accept; driven only from registered state
- in_ctrl_i  in  CTRL_W  upstream control
- in_data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  downstream accepts
- out_ctrl_o  out  CTRL_W  head control (0 when not valid)
- out_data_o  out  DATA_W  head payload (0 when not valid)
- occupancy_o  out  2  entries held: 0, 1 or 2

## Operation
- in_fire = in_valid_i & in_ready_o.
- out_fire = out_valid_o & out_ready_i.
- Storage: main register (head) and skid register.
- States: EMPTY, ONE (main full), TWO (main and skid full).
- in_ready_o = (state != TWO).
- out_valid_o = (state != EMPTY).
- Outputs always come from main.
- EMPTY: in_fire → ONE, main ← in.
- ONE:
  - in_fire & out_fire → ONE, main ← in.
  - in_fire & !out_fire → TWO, skid ← in.
  - !in_fire & out_fire → EMPTY.
  - Otherwise hold.
- TWO:
  - out_fire → ONE, main ← skid.
  - Otherwise hold. No in_fire is possible in TWO.
- Flush (|flush_i):
  - Highest priority after reset.
  - state ← EMPTY; main and skid ctrl/data ← 0.
  - Any in_fire or out_fire in the same cycle is discarded: the stage performs no write, and its contents are squashed.
  - Upstream sees its handshake complete and must not resend.
- Reset: identical to flush.
- Cleared control is an all-zero bubble: no register write, no memory access.

## Timing
- Reset values: out_valid_o=0, out_ctrl_o=0, out_data_o=0, in_ready_o=1, occupancy_o=0.
- Latency: in_fire at cycle N → out_valid_o with that bundle at N+1.
- Throughput: one bundle per cycle while out_ready_i=1.
- Backpressure: a single stall cycle moves the state to TWO, and in_ready_o drops at the next edge. No bundle is lost or duplicated.
- No combinational path from out_ready_i to in_ready_o.
- Flush asserted at cycle N: out_valid_o=0 and in_ready_o=1 from N+1.
- Stage contents are a registered snapshot only. Stall in TWO holds both entries indefinitely.

## Configuration
- PIPE_STAGE_PERF_EN defined adds two ports:
  - stall_cnt_o out 16: counts cycles with out_valid_o & !out_ready_i.
  - flush_cnt_o out 16: counts flush cycles while occupancy_o != 0.
- Both counters saturate at 16'hFFFF and reset to 0 on rst_n. Flush does not clear them.
- PIPE_STAGE_PERF_EN undefined: ports and counters are absent, and datapath behaviour is identical.

## Structure
- Package pipe_stage_pkg holds:
  - state enum (EMPTY/ONE/TWO).
  - field widths WB_W=2, MEM_W=2, EX_W=7, CTRL_W_DEF=11.
  - CNT_W=16.
- Sub-module sat_counter (CNT_W wide, inc/clear inputs, saturating) is instantiated twice under PIPE_STAGE_PERF_EN.

## Test plan
- Streaming: out_ready_i=1, send ctrl 11'h155/data 1..10 back-to-back → each appears one cycle later in order, and in_ready_o stays 1.
- Backpressure: send A, B with out_ready_i=0 from the cycle A appears → occupancy_o=2, in_ready_o=0. Release → A then B on consecutive cycles, no loss.
- Flush in TWO: state TWO, pulse flush_i=2'b10 one cycle → next cycle out_valid_o=0, out_ctrl_o=0, occupancy_o=0, in_ready_o=1.
- Flush with simultaneous in_fire: flush_i=2'b01 while in_valid_i=1 → incoming bundle is dropped and the output stays a bubble.
- Mid-operation reset: rst_n=0 for one edge in TWO → all outputs at reset values. Drain nothing afterwards.
- PERF: 3 stall cycles and 2 flushes of a non-empty stage → stall_cnt_o=3, flush_cnt_o=2. Force 70000 stall cycles → stall_cnt_o=16'hFFFF.
